uart_tx_arbiter: RTL

- Shares the single UART transmitter between NUM_REQ byte producers.
- Uses round-robin arbitration and sequences each transfer: latch byte, pulse tx_start, wait for tx_done.
- Sits between the producer blocks and the UART TX datapath's tx_data input, on the same clk/reset as the UART top.
- Adds a watchdog that flags a transmitter that never completes.

---
 rtl/uart_ctrl_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control blocks (TX arbiter, planned RX dispatcher).
// Contents: FSM state encodings, default byte width, constant clog2 helper.
package uart_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t START     = 2'd1;
  localparam state_t WAIT_DONE = 2'd2;

  localparam int DEFAULT_DATA_W = 8;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req       - request vector, one bit per lane
//   pointer   - lane served last; search starts at pointer+1 and wraps
//   grant     - one-hot winner (all zero when no request)
//   grant_idx - index of the winner
//   any       - at least one request present
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  int            sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = 0;
    idx       = '0;
    // Offsets 1..NUM_REQ: the lane at the pointer itself is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(pointer) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_W'(sum);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers with round-robin
// arbitration, sequences each transfer and watches for a stuck transmitter.
// Ports:
//   clk, reset          - system clock, async active-high reset
//   req, req_data       - per-lane request level and byte (lane i at [i*DATA_W +: DATA_W])
//   grant, owner        - one-cycle one-hot accept pulse, index of current/last owner
//   tx_start, tx_data   - start pulse and held byte towards the UART TX datapath
//   tx_busy, tx_done    - transmitter status and end-of-stop-bit pulse
//   err_clr, timeout_err- clear input and sticky watchdog flag
//
// state     | meaning
// IDLE      | waiting for a request while the transmitter is free
// START     | byte latched, grant pulsing; tx_start issued at the closing edge
// WAIT_DONE | transmitter shifting; timer running until tx_done or timeout
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  DATA_W  = DEFAULT_DATA_W,
  parameter int  TIMEOUT = 2048,
  localparam int ID_W    = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ID_W-1:0]           owner,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  input  logic                      err_clr,
  output logic                      timeout_err
);

  // One extra bit so the counter can never wrap before the compare.
  localparam int TMR_W = clog2(TIMEOUT) + 1;

  state_t              state;
  logic [ID_W-1:0]     pointer;
  logic [TMR_W-1:0]    timer;

  logic [NUM_REQ-1:0]  win_onehot;
  logic [ID_W-1:0]     win_idx;
  logic                win_any;
  logic [DATA_W-1:0]   lane_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_data[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req),
    .pointer   (pointer),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pointer     <= ID_W'(NUM_REQ - 1);
      timer       <= '0;
      grant       <= '0;
      owner       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      grant    <= '0;
      tx_start <= 1'b0;
      // A timeout below overrides this clear in the same cycle.
      if (err_clr) timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (win_any && !tx_busy) begin
            tx_data <= lane_data[win_idx];
            owner   <= win_idx;
            grant   <= win_onehot;
            state   <= START;
          end
        end
        START: begin
          tx_start <= 1'b1;
          timer    <= '0;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          timer <= timer + 1'b1;
          if (tx_done) begin
            pointer <= owner;
            state   <= IDLE;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            pointer     <= owner;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
